// File: rtl/mask_compact_sched_if.sv
// Handshake bundle between the mask producer and the gather/compaction consumer.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready; slave = scheduler side, master = producer/consumer side.
// Port summary: in_valid/in_ready/in_mask (mask in), out_valid/out_ready/out_idx/
//   out_lane_valid/out_last/out_count (index beats out).
interface mask_compact_sched_if #(
  parameter int LANES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_mask;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*5-1:0]     out_idx;
  logic [LANES-1:0]       out_lane_valid;
  logic                   out_last;
  logic [5:0]             out_count;

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_idx, out_lane_valid, out_last, out_count
  );

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_idx, out_lane_valid, out_last, out_count
  );
endinterface

// File: rtl/mask_compact_sched.sv
// Compacts a 32-bit keep-mask into ascending set-bit indices, LANES per beat.
// Latency: first beat 2 cycles after the accept handshake, then one beat per cycle.
// Backpressure: beat and group counter hold while out_ready=0; in_ready=1 only in IDLE.
// Ports: clk, reset_n (async active-low), bus (slave modport of mask_compact_sched_if).
module mask_compact_sched #(
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mask_compact_sched_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_EMIT} state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [31:0]  r_mask;
  logic [5:0]   r_psum [32];
  logic [5:0]   r_total;
  logic [5:0]   r_g;

  // Prefix network levels: w_p[0] is the mask itself, w_p[5] the inclusive sums.
  logic [5:0]   w_p [6][32];
  logic [4:0]   w_src;

  logic                  w_emit;
  logic                  w_last;
  logic [6:0]            w_base;
  logic [6:0]            w_slot;
  logic [6:0]            w_total_ext;
  logic [4:0]            w_sel;
  logic [LANES*5-1:0]    w_idx;
  logic [LANES-1:0]      w_lv;

  // Ladner-Fischer (minimum-depth form): at level l, every lane with bit l set
  // adds the running sum of the last lane of the preceding 2^l block.
  always_comb begin
    w_src = '0;
    for (int i = 0; i < 32; i++) begin
      w_p[0][i] = {5'd0, r_mask[i]};
    end
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < 32; i++) begin
        if (((i >> l) & 1) == 1) begin
          w_src         = 5'(((i >> l) << l) - 1);
          w_p[l+1][i]   = w_p[l][i] + w_p[l][w_src];
        end else begin
          w_p[l+1][i]   = w_p[l][i];
        end
      end
    end
  end

  // Lane selection: set bit i owns slot psum[i]-1; compared as psum[i] == slot+1
  // so no subtraction can underflow on cleared positions.
  always_comb begin
    w_emit      = (r_state == S_EMIT);
    w_base      = 7'(r_g) * 7'(LANES);
    w_total_ext = {1'b0, r_total};
    w_slot      = '0;
    w_sel       = '0;
    w_idx       = '0;
    w_lv        = '0;
    for (int k = 0; k < LANES; k++) begin
      w_slot = w_base + 7'(k);
      w_lv[k] = w_emit && (w_slot < w_total_ext);
      w_sel = '0;
      for (int i = 0; i < 32; i++) begin
        if (r_mask[i] && ({1'b0, r_psum[i]} == (w_slot + 7'd1))) begin
          w_sel = w_sel | 5'(i);
        end
      end
      if (w_lv[k]) begin
        w_idx[k*5 +: 5] = w_sel;
      end
    end
    // A zero mask still terminates with one empty last beat.
    w_last = w_emit && ((w_base + 7'(LANES)) >= w_total_ext);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // in_ready is a pure function of state; out_ready only steers the next state.
  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt = S_PREP;
        end
      end
      S_PREP: begin
        w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready && w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask  <= '0;
      r_total <= '0;
      r_g     <= '0;
      for (int i = 0; i < 32; i++) begin
        r_psum[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_mask <= bus.in_mask;
          end
        end
        S_PREP: begin
          for (int i = 0; i < 32; i++) begin
            r_psum[i] <= w_p[5][i];
          end
          r_total <= w_p[5][31];
          r_g     <= '0;
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            r_g <= r_g + 6'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.out_idx        = w_idx;
  assign bus.out_lane_valid = w_lv;
  assign bus.out_last       = w_last;
  assign bus.out_count      = r_total;

endmodule
